rv_decode_stage: RTL and testbench

Registered RV32I/RV64I decode stage between instruction fetch and register read. Accepts one 32-bit instruction per cycle over a valid/ready handshake. Emits decoded fields (format, register indices, funct3, alt bit, sign-extended immediate, illegal flag) one cycle later through a two-entry skid buffer. Parametrised for XLEN (32/64) and register-file size (32 = I, 16 = E), and keeps a saturating illegal-instruction counter.

---
 rtl/rv_decode_stage.sv | 194 +++++++++++++++++++
 tb/tb_rv_decode_stage.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/rv_decode_stage.sv
// RV32I/RV64I decode stage: classifies one instruction per cycle, outputs decoded fields one cycle later.
// in_ready comes only from the registered skid state; a two-entry skid buffer absorbs one beat after out_ready drops.
module rv_decode_stage #(
   parameter int XLEN     = 32,
   parameter int NUM_REGS = 32
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [31:0]                 in_instr,
   input  logic [XLEN-1:0]             in_pc,
   input  logic                        flush,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [XLEN-1:0]             out_pc,
   output logic [2:0]                  out_fmt,
   output logic [$clog2(NUM_REGS)-1:0] out_rs1,
   output logic [$clog2(NUM_REGS)-1:0] out_rs2,
   output logic [$clog2(NUM_REGS)-1:0] out_rd,
   output logic [2:0]                  out_funct3,
   output logic                        out_alt,
   output logic [XLEN-1:0]             out_imm,
   output logic                        out_illegal,
   output logic [15:0]                 ill_count
);

   localparam int RW = $clog2(NUM_REGS);

   localparam logic [2:0] FMT_R    = 3'd0;
   localparam logic [2:0] FMT_I    = 3'd1;
   localparam logic [2:0] FMT_S    = 3'd2;
   localparam logic [2:0] FMT_B    = 3'd3;
   localparam logic [2:0] FMT_U    = 3'd4;
   localparam logic [2:0] FMT_J    = 3'd5;
   localparam logic [2:0] FMT_NONE = 3'd7;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [2:0]      fmt;
      logic [RW-1:0]   rs1;
      logic [RW-1:0]   rs2;
      logic [RW-1:0]   rd;
      logic [2:0]      funct3;
      logic            alt;
      logic [XLEN-1:0] imm;
      logic            illegal;
   } entry_t;

   typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

   state_t      state, state_nxt;
   entry_t      dec, head, skid;
   logic [2:0]  fmt;
   logic [31:0] imm32;
   logic        use_rs1, use_rs2, use_rd, reg_hi, bad_funct7;
   logic        accept, pop, ld_head_in, ld_head_skid, ld_skid;

   always_comb begin
      dec     = '0;
      fmt     = FMT_NONE;
      imm32   = '0;
      use_rs1 = 1'b0;
      use_rs2 = 1'b0;
      use_rd  = 1'b0;
      case (in_instr[6:2])
         5'b01100:                                         fmt = FMT_R;
         5'b01110:                                         fmt = (XLEN == 64) ? FMT_R : FMT_NONE;
         5'b00000, 5'b00011, 5'b00100, 5'b11001, 5'b11100: fmt = FMT_I;
         5'b00110:                                         fmt = (XLEN == 64) ? FMT_I : FMT_NONE;
         5'b01000:                                         fmt = FMT_S;
         5'b11000:                                         fmt = FMT_B;
         5'b00101, 5'b01101:                               fmt = FMT_U;
         5'b11011:                                         fmt = FMT_J;
         default:                                          fmt = FMT_NONE;
      endcase
      case (fmt)
         FMT_R: begin
            use_rs1 = 1'b1; use_rs2 = 1'b1; use_rd = 1'b1;
         end
         FMT_I: begin
            use_rs1 = 1'b1; use_rd = 1'b1;
            imm32   = {{20{in_instr[31]}}, in_instr[31:20]};
         end
         FMT_S: begin
            use_rs1 = 1'b1; use_rs2 = 1'b1;
            imm32   = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
         end
         FMT_B: begin
            use_rs1 = 1'b1; use_rs2 = 1'b1;
            imm32   = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                       in_instr[11:8], 1'b0};
         end
         FMT_U: begin
            use_rd = 1'b1;
            imm32  = {in_instr[31:12], 12'h000};
         end
         FMT_J: begin
            use_rd = 1'b1;
            imm32  = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                      in_instr[30:21], 1'b0};
         end
         default: ;
      endcase

      // Bit 4 of a raw register field only matters for the 16-register variant.
      reg_hi     = (NUM_REGS == 16) && ((use_rs1 && in_instr[19]) ||
                                        (use_rs2 && in_instr[24]) ||
                                        (use_rd  && in_instr[11]));
      bad_funct7 = (fmt == FMT_R) && (in_instr[31:25] != 7'h00) && (in_instr[31:25] != 7'h20);

      dec.pc      = in_pc;
      dec.fmt     = fmt;
      dec.rs1     = use_rs1 ? in_instr[15 +: RW] : '0;
      dec.rs2     = use_rs2 ? in_instr[20 +: RW] : '0;
      dec.rd      = use_rd  ? in_instr[7 +: RW]  : '0;
      dec.funct3  = use_rs1 ? in_instr[14:12] : 3'd0;
      dec.alt     = ((fmt == FMT_R) || (fmt == FMT_I && in_instr[14:12] == 3'b101)) && in_instr[30];
      dec.imm     = {{(XLEN-31){imm32[31]}}, imm32[30:0]};
      dec.illegal = (in_instr[1:0] != 2'b11) || (fmt == FMT_NONE) || bad_funct7 || reg_hi;
   end

   assign in_ready  = (state != TWO);
   assign out_valid = (state != EMPTY);
   assign accept    = in_valid & in_ready & ~flush;
   assign pop       = out_valid & out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= EMPTY;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt    = state;
      ld_head_in   = 1'b0;
      ld_head_skid = 1'b0;
      ld_skid      = 1'b0;
      case (state)
         EMPTY: if (accept) begin
            ld_head_in = 1'b1;
            state_nxt  = ONE;
         end
         ONE: begin
            if (accept && pop) begin
               ld_head_in = 1'b1;
            end else if (accept) begin
               ld_skid   = 1'b1;
               state_nxt = TWO;
            end else if (pop) begin
               state_nxt = EMPTY;
            end
         end
         TWO: if (pop) begin
            ld_head_skid = 1'b1;
            state_nxt    = ONE;
         end
         default: state_nxt = EMPTY;
      endcase
      if (flush) begin
         state_nxt    = EMPTY;
         ld_head_in   = 1'b0;
         ld_head_skid = 1'b0;
         ld_skid      = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head <= '0;
         skid <= '0;
      end else begin
         if (ld_head_in)        head <= dec;
         else if (ld_head_skid) head <= skid;
         if (ld_skid)           skid <= dec;
      end
   end

   // A pop coinciding with flush is still a real handoff, so it is counted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                                ill_count <= '0;
      else if (pop && head.illegal && ill_count != 16'hFFFF) ill_count <= ill_count + 16'd1;
   end

   assign out_pc      = head.pc;
   assign out_fmt     = head.fmt;
   assign out_rs1     = head.rs1;
   assign out_rs2     = head.rs2;
   assign out_rd      = head.rd;
   assign out_funct3  = head.funct3;
   assign out_alt     = head.alt;
   assign out_imm     = head.imm;
   assign out_illegal = head.illegal;

endmodule

// File: tb/tb_rv_decode_stage.sv
// Bench for rv_decode_stage: an RV32I/32-reg and an RV64/16-reg instance share one stimulus stream,
// each checked against a queue-based reference of the decode rules and skid occupancy.
module tb_rv_decode_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, flush, out_ready;
   logic [31:0] in_instr;
   logic [63:0] pc64;

   always #5 clk = ~clk;

   logic        a_in_ready, a_out_valid, a_alt, a_ill;
   logic [31:0] a_pc, a_imm;
   logic [2:0]  a_fmt, a_f3;
   logic [4:0]  a_rs1, a_rs2, a_rd;
   logic [15:0] a_cnt;

   logic        b_in_ready, b_out_valid, b_alt, b_ill;
   logic [63:0] b_pc, b_imm;
   logic [2:0]  b_fmt, b_f3;
   logic [3:0]  b_rs1, b_rs2, b_rd;
   logic [15:0] b_cnt;

   rv_decode_stage #(.XLEN(32), .NUM_REGS(32)) dut_a (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready), .in_instr(in_instr),
      .in_pc(pc64[31:0]), .flush(flush), .out_valid(a_out_valid), .out_ready(out_ready),
      .out_pc(a_pc), .out_fmt(a_fmt), .out_rs1(a_rs1), .out_rs2(a_rs2), .out_rd(a_rd),
      .out_funct3(a_f3), .out_alt(a_alt), .out_imm(a_imm), .out_illegal(a_ill), .ill_count(a_cnt));

   rv_decode_stage #(.XLEN(64), .NUM_REGS(16)) dut_b (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready), .in_instr(in_instr),
      .in_pc(pc64), .flush(flush), .out_valid(b_out_valid), .out_ready(out_ready),
      .out_pc(b_pc), .out_fmt(b_fmt), .out_rs1(b_rs1), .out_rs2(b_rs2), .out_rd(b_rd),
      .out_funct3(b_f3), .out_alt(b_alt), .out_imm(b_imm), .out_illegal(b_ill), .ill_count(b_cnt));

   typedef struct packed {
      logic [2:0]  fmt;
      logic [4:0]  rs1, rs2, rd;
      logic [2:0]  f3;
      logic        alt;
      logic [63:0] imm;
      logic        ill;
   } exp_t;

   typedef struct {
      logic [63:0] pc;
      exp_t        e32;
      exp_t        e64;
   } item_t;

   item_t       q[$];
   int unsigned ill32, ill64, n_popped;
   int          n_chk = 0, n_pass = 0;

   logic [6:0] op_tbl [0:13] = '{7'h33, 7'h3B, 7'h03, 7'h0F, 7'h13, 7'h67, 7'h73,
                                 7'h1B, 7'h23, 7'h63, 7'h17, 7'h37, 7'h6F, 7'h0B};

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
   endtask

   // Reference decode written from the opcode map (full 7-bit major opcodes).
   function automatic exp_t ref_decode(input logic [31:0] w, input int xlen, input int nregs);
      exp_t   e;
      longint v;
      bit     r1, r2, rdu;
      e = '0; v = 0; r1 = 0; r2 = 0; rdu = 0;
      case ({w[6:2], 2'b11})
         7'h33:                      e.fmt = 3'd0;
         7'h3B:                      e.fmt = (xlen == 64) ? 3'd0 : 3'd7;
         7'h03, 7'h0F, 7'h13, 7'h67, 7'h73: e.fmt = 3'd1;
         7'h1B:                      e.fmt = (xlen == 64) ? 3'd1 : 3'd7;
         7'h23:                      e.fmt = 3'd2;
         7'h63:                      e.fmt = 3'd3;
         7'h17, 7'h37:               e.fmt = 3'd4;
         7'h6F:                      e.fmt = 3'd5;
         default:                    e.fmt = 3'd7;
      endcase
      case (e.fmt)
         3'd0: begin r1 = 1; r2 = 1; rdu = 1; end
         3'd1: begin r1 = 1; rdu = 1; v = $signed(w[31:20]); end
         3'd2: begin r1 = 1; r2 = 1; v = $signed({w[31:25], w[11:7]}); end
         3'd3: begin r1 = 1; r2 = 1; v = $signed({w[31], w[7], w[30:25], w[11:8], 1'b0}); end
         3'd4: begin rdu = 1; v = $signed({w[31:12], 12'h000}); end
         3'd5: begin rdu = 1; v = $signed({w[31], w[19:12], w[20], w[30:21], 1'b0}); end
         default: ;
      endcase
      e.imm = (xlen == 32) ? (64'(v) & 64'hFFFF_FFFF) : 64'(v);
      if (r1)  e.rs1 = 5'(int'(w[19:15]) % nregs);
      if (r2)  e.rs2 = 5'(int'(w[24:20]) % nregs);
      if (rdu) e.rd  = 5'(int'(w[11:7]) % nregs);
      if (r1)  e.f3  = w[14:12];
      e.alt = ((e.fmt == 3'd0) || (e.fmt == 3'd1 && w[14:12] == 3'd5)) ? w[30] : 1'b0;
      e.ill = (w[1:0] != 2'b11) || (e.fmt == 3'd7) ||
              (e.fmt == 3'd0 && w[31:25] != 7'h00 && w[31:25] != 7'h20) ||
              (nregs == 16 && ((r1 && w[19:15] >= 16) || (r2 && w[24:20] >= 16) ||
                               (rdu && w[11:7] >= 16)));
      return e;
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [31:0] w;
      w = $urandom();
      if ($urandom_range(0, 9) < 8) w[6:0] = op_tbl[$urandom_range(0, 13)];
      if ((w[6:0] == 7'h33 || w[6:0] == 7'h3B) && $urandom_range(0, 3) != 0)
         w[31:25] = $urandom_range(0, 1) ? 7'h20 : 7'h00;
      if ($urandom_range(0, 1)) begin w[24] = 0; w[19] = 0; w[11] = 0; end
      return w;
   endfunction

   // One clock: drive at negedge, check registered outputs, advance the model, end at next negedge.
   task automatic step(input logic v, input logic [31:0] w, input logic fl, input logic ordy);
      item_t it;
      bit    acc, pp;
      in_valid = v; in_instr = w; flush = fl; out_ready = ordy;
      pc64 = {$urandom(), $urandom()};
      #1;
      chk("a_in_ready", a_in_ready, q.size() < 2);
      chk("b_in_ready", b_in_ready, q.size() < 2);
      chk("a_out_valid", a_out_valid, q.size() > 0);
      chk("b_out_valid", b_out_valid, q.size() > 0);
      chk("a_ill_count", a_cnt, ill32);
      chk("b_ill_count", b_cnt, ill64);
      if (q.size() > 0) begin
         chk("a_pc", a_pc, q[0].pc & 64'hFFFF_FFFF);  chk("b_pc", b_pc, q[0].pc);
         chk("a_fmt", a_fmt, q[0].e32.fmt);           chk("b_fmt", b_fmt, q[0].e64.fmt);
         chk("a_rs1", a_rs1, q[0].e32.rs1);           chk("b_rs1", b_rs1, q[0].e64.rs1);
         chk("a_rs2", a_rs2, q[0].e32.rs2);           chk("b_rs2", b_rs2, q[0].e64.rs2);
         chk("a_rd", a_rd, q[0].e32.rd);              chk("b_rd", b_rd, q[0].e64.rd);
         chk("a_funct3", a_f3, q[0].e32.f3);          chk("b_funct3", b_f3, q[0].e64.f3);
         chk("a_alt", a_alt, q[0].e32.alt);           chk("b_alt", b_alt, q[0].e64.alt);
         chk("a_imm", a_imm, q[0].e32.imm);           chk("b_imm", b_imm, q[0].e64.imm);
         chk("a_illegal", a_ill, q[0].e32.ill);       chk("b_illegal", b_ill, q[0].e64.ill);
      end
      acc = v && (q.size() < 2) && !fl;
      pp  = (q.size() > 0) && ordy;
      if (pp) begin
         if (q[0].e32.ill && ill32 < 65535) ill32++;
         if (q[0].e64.ill && ill64 < 65535) ill64++;
         n_popped++;
         void'(q.pop_front());
      end
      if (fl) q.delete();
      else if (acc) begin
         it.pc  = pc64;
         it.e32 = ref_decode(w, 32, 32);
         it.e64 = ref_decode(w, 64, 16);
         q.push_back(it);
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   logic [31:0] bp_list [0:3] = '{32'h00100113, 32'h00200193, 32'h00300213, 32'h00400293};

   initial begin
      int          idx, pops0;
      logic [31:0] w;
      rst = 1'b1; in_valid = 0; in_instr = '0; flush = 0; out_ready = 0; pc64 = '0;
      ill32 = 0; ill64 = 0; n_popped = 0;
      repeat (2) @(negedge clk);
      chk("rst_out_valid", a_out_valid, 0);
      chk("rst_in_ready", a_in_ready, 1);
      chk("rst_ill_count", a_cnt, 0);
      chk("rst_imm", a_imm, 0);
      chk("rst_fmt", b_fmt, 0);
      rst = 1'b0;

      // Directed decode examples.
      step(1, 32'hFFF00093, 0, 0);
      chk("addi_valid", a_out_valid, 1); chk("addi_fmt", a_fmt, 1); chk("addi_rd", a_rd, 1);
      chk("addi_imm", a_imm, 32'hFFFF_FFFF); chk("addi_imm64", b_imm, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("addi_ill", a_ill, 0);
      step(1, 32'hFE000EE3, 0, 1);
      chk("beq_fmt", a_fmt, 3); chk("beq_imm", a_imm, 32'hFFFF_FFFC); chk("beq_rd", a_rd, 0);
      step(1, 32'h123452B7, 0, 1);
      chk("lui_rd", a_rd, 5); chk("lui_imm", a_imm, 32'h1234_5000);
      chk("lui_imm64", b_imm, 64'h0000_0000_1234_5000);
      step(1, 32'h00208833, 0, 1);
      chk("add16_ill", b_ill, 1); chk("add16_rd", b_rd, 0); chk("add32_rd", a_rd, 16);
      step(1, 32'h00000000, 0, 1);
      chk("zero_ill", a_ill, 1);
      step(0, 32'h0, 0, 1);
      chk("ill_count_e", b_cnt, 2); chk("ill_count_i", a_cnt, 1);

      // Backpressure: four instructions with downstream stalled, then drained.
      idx = 0; pops0 = n_popped;
      for (int c = 0; c < 4; c++) begin
         w = bp_list[idx];
         if (q.size() < 2 && idx < 4) begin step(1, w, 0, 0); idx++; end
         else step(1, w, 0, 0);
         if (idx == 2 && c == 1) chk("bp_in_ready_low", a_in_ready, 0);
      end
      for (int c = 0; c < 12 && (idx < 4 || q.size() > 0); c++) begin
         w = bp_list[idx < 4 ? idx : 3];
         if (idx < 4 && q.size() < 2) begin step(1, w, 0, 1); idx++; end
         else step(idx < 4, w, 0, 1);
      end
      chk("bp_drained", n_popped - pops0, 4);

      // Flush while full, with a concurrent input.
      step(1, 32'h00500313, 0, 0);
      step(1, 32'h00600393, 0, 0);
      step(1, 32'h00700413, 1, 0);
      chk("flush_out_valid", a_out_valid, 0); chk("flush_in_ready", a_in_ready, 1);
      step(0, 32'h0, 0, 1);
      step(0, 32'h0, 0, 1);

      // Randomized traffic.
      for (int c = 0; c < 3000; c++)
         step($urandom_range(0, 9) < 7, rand_instr(), $urandom_range(0, 99) < 3,
              $urandom_range(0, 9) < 6);

      // Asynchronous reset between edges with entries held.
      step(1, 32'h00000000, 0, 0);
      step(1, 32'h00000001, 0, 0);
      #2 rst = 1'b1;
      #1;
      chk("arst_out_valid", a_out_valid, 0);
      chk("arst_ill_count_a", a_cnt, 0);
      chk("arst_ill_count_b", b_cnt, 0);
      chk("arst_in_ready", b_in_ready, 1);
      q.delete(); ill32 = 0; ill64 = 0;
      @(negedge clk);
      rst = 1'b0;

      // Saturation of the illegal counter.
      for (int c = 0; c < 65540; c++) step(1, 32'h00000000, 0, 1);
      chk("sat_a", a_cnt, 16'hFFFF);
      chk("sat_b", b_cnt, 16'hFFFF);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
